// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants and state encoding for the score BCD converter
package score_pkg;

  localparam int SCORE_DIGITS = 6;
  localparam int SCORE_MAX    = 999999;
  localparam int SCORE_WORK_W = 20;

  // Low byte of the Seg7 word carries no digits
  localparam logic [7:0] SEG_PAD = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } score_state_e;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble adjust, add 3 when the digit is 5 or more
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // 4-bit add with no carry out; a digit of 5..9 never overflows the nibble
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - sequential binary-to-BCD converter feeding the Seg7 driver
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int BIN_W        = 32,
  parameter int DIGITS       = score_pkg::SCORE_DIGITS,
  parameter int SCORE_MAX    = score_pkg::SCORE_MAX,
  parameter int WORK_W       = score_pkg::SCORE_WORK_W,
  parameter int AUTO_REFRESH = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [31:0]           seg_data,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WORK_W;
  localparam int CNT_W = (WORK_W > 1) ? $clog2(WORK_W) : 1;

  score_state_e       state_q;
  score_state_e       state_d;
  logic [SR_W-1:0]    sr;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   last_bin;
  logic               ovf_pend;
  logic               over;
  logic [WORK_W-1:0]  sat;
  logic               start;
  logic               last_shift;

  // Saturation is decided on the full-width input before truncation
  assign over       = (bin > BIN_W'(SCORE_MAX));
  assign sat        = over ? WORK_W'(SCORE_MAX) : bin[WORK_W-1:0];
  assign last_shift = (cnt == CNT_W'(WORK_W - 1));
  assign start      = in_ready && ((AUTO_REFRESH != 0) ? (bin != last_bin) : in_valid);

  // Every digit of the BCD field is adjusted in parallel before each shift
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr[WORK_W + 4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; the out_valid cycle is the tail of a conversion, so
  // a new request is taken only once the pulse has gone
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !out_valid;
    busy     = (state_q != ST_IDLE) || out_valid;
  end

  // Datapath: capture on accept, shift during SHIFT, publish in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      last_bin  <= '0;
      ovf_pend  <= 1'b0;
      ovf       <= 1'b0;
      bcd       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_q == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sr       <= {{BCD_W{1'b0}}, sat};
            cnt      <= '0;
            ovf_pend <= over;
            last_bin <= bin;
          end
        end
        ST_SHIFT: begin
          sr  <= {adj[BCD_W-2:0], sr[WORK_W-1:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        ST_DONE: begin
          bcd <= sr[SR_W-1:WORK_W];
          ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign seg_data = {bcd, SEG_PAD};

endmodule
